// File: rtl/mac_fifo_seq.sv
// Sequences one MAC job: fills operand FIFOs A/B in lockstep, drains them into the MAC, then pulses done.
// Latency: mac_clr one cycle after start; mac_en one cycle after each FIFO read; done two cycles after the last read.
// Backpressure: in_ready drops when the job length is reached or either FIFO is full; reads stall on empty/mismatched flags.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset shared with the FIFOs
//   start, len          job request and pair count, sampled only in IDLE
//   in_valid, in_ready  upstream pair handshake (pair data goes straight to the FIFO write data)
//   a_/b_full, a_/b_empty   FIFO status flags
//   a_/b_wren, a_/b_rden    FIFO write / read enables
//   mac_clr, mac_en     MAC accumulator clear and accumulate strobes
//   busy, done, err     job in progress, job-complete pulse, sticky A/B empty-flag mismatch
module mac_fifo_seq #(
    parameter int DEPTH = 8,
    parameter int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a_full,
    input  logic             b_full,
    input  logic             a_empty,
    input  logic             b_empty,
    output logic             a_wren,
    output logic             b_wren,
    output logic             a_rden,
    output logic             b_rden,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_DRAIN = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [LEN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    logic             mac_clr_q, mac_en_q, busy_q, done_q;

    logic             wr;
    logic             rd;
    logic             start_acc;

    // Next-state and combinational outputs
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        drain_cnt_d = drain_cnt_q;
        len_d       = len_q;
        err_d       = err_q;
        in_ready    = 1'b0;
        wr          = 1'b0;
        rd          = 1'b0;
        start_acc   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc   = 1'b1;
                    // Clamp so the job never asks for more than one FIFO's worth
                    len_d       = (len > DEPTH_L) ? DEPTH_L : len;
                    fill_cnt_d  = '0;
                    drain_cnt_d = '0;
                    err_d       = 1'b0;
                    state_d     = (len == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                // Full-width compare: fill_cnt reaches DEPTH without wrapping
                in_ready = (fill_cnt_q < len_q) && !a_full && !b_full;
                wr       = in_valid && in_ready;
                if (wr) begin
                    fill_cnt_d = fill_cnt_q + ONE_L;
                    if (fill_cnt_q + ONE_L == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // A and B are written in lockstep, so differing empty flags mean
                // the FIFOs have diverged; hold reads off until they agree.
                if (a_empty != b_empty) begin
                    err_d = 1'b1;
                end
                rd = (drain_cnt_q < len_q) && !a_empty && !b_empty;
                if (rd) begin
                    drain_cnt_d = drain_cnt_q + ONE_L;
                    if (drain_cnt_q + ONE_L == len_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Last read's data is on the FIFO outputs now; mac_en covers it
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fill_cnt_q  <= '0;
            drain_cnt_q <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            len_q       <= len_d;
            err_q       <= err_d;
            mac_clr_q   <= start_acc;
            // FIFO read data is registered, so the MAC strobe trails the read by one cycle
            mac_en_q    <= rd;
            busy_q      <= (state_d == S_FILL) || (state_d == S_DRAIN) || (state_d == S_FLUSH);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign a_wren  = wr;
    assign b_wren  = wr;
    assign a_rden  = rd;
    assign b_rden  = rd;
    assign mac_clr = mac_clr_q;
    assign mac_en  = mac_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mac_fifo_seq.sv
// Bench for mac_fifo_seq: models two FIFOs around the sequencer and checks per-cycle strobe patterns.
// Latency: each job is observed over a fixed window of cycles starting at the start cycle.
// Backpressure: upstream stalls and a forced B-empty mismatch are driven from the vector table.
module tb_mac_fifo_seq;

    localparam int DEPTH = 8;
    localparam int LEN_W = 4;
    localparam int NCYC  = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic             a_full, b_full, a_empty, b_empty;
    logic             a_wren, b_wren, a_rden, b_rden;
    logic             mac_clr, mac_en, busy, done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_fifo_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_full   (a_full),
        .b_full   (b_full),
        .a_empty  (a_empty),
        .b_empty  (b_empty),
        .a_wren   (a_wren),
        .b_wren   (b_wren),
        .a_rden   (a_rden),
        .b_rden   (b_rden),
        .mac_clr  (mac_clr),
        .mac_en   (mac_en),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Two FIFO models with one-cycle registered read data.
    // Pair w carries A = w+1 and B = 2w+3, so order can be checked at the MAC.
    int qa[$];
    int qb[$];
    int a_cnt, b_cnt;
    int wr_idx = 0;
    int a_odat, b_odat;
    logic force_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            a_cnt <= 0;
            b_cnt <= 0;
        end else begin
            if (a_wren) qa.push_back(wr_idx + 1);
            if (b_wren) qb.push_back(2 * wr_idx + 3);
            if (a_wren) wr_idx <= wr_idx + 1;
            if (a_rden && qa.size() > 0) a_odat <= qa.pop_front();
            if (b_rden && qb.size() > 0) b_odat <= qb.pop_front();
            a_cnt <= a_cnt + (a_wren ? 1 : 0) - (a_rden ? 1 : 0);
            b_cnt <= b_cnt + (b_wren ? 1 : 0) - (b_rden ? 1 : 0);
        end
    end

    assign a_full  = (a_cnt == DEPTH);
    assign b_full  = (b_cnt == DEPTH);
    assign a_empty = (a_cnt == 0);
    assign b_empty = (b_cnt == 0) || force_b;

    typedef struct {
        logic [LEN_W-1:0] len;
        logic [63:0] stall;   // in_valid low in these cycles
        logic [63:0] forceb;  // b_empty forced high in these cycles
        logic [63:0] wren, rden, mac, done, busy, clr, rdy, full, err;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_job(input string tag, input vec_t v);
        logic [63:0] h_wren, h_rden, h_mac, h_done, h_busy, h_clr, h_rdy, h_full, h_err;
        int lockstep_bad;
        int exp_a;
        h_wren = '0; h_rden = '0; h_mac = '0; h_done = '0; h_busy = '0;
        h_clr = '0; h_rdy = '0; h_full = '0; h_err = '0;
        lockstep_bad = 0;
        exp_a = wr_idx + 1;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            start    = (c == 0);
            len      = v.len;
            in_valid = !v.stall[c];
            force_b  = v.forceb[c];
            @(negedge clk);
            h_wren[c] = a_wren;
            h_rden[c] = a_rden;
            h_mac[c]  = mac_en;
            h_done[c] = done;
            h_busy[c] = busy;
            h_clr[c]  = mac_clr;
            h_rdy[c]  = in_ready;
            h_full[c] = a_full;
            h_err[c]  = err;
            if (a_wren != b_wren || a_rden != b_rden) lockstep_bad++;
            if (mac_en) begin
                chk($sformatf("%s order A c%0d", tag, c), 64'(a_odat), 64'(exp_a));
                chk($sformatf("%s order B c%0d", tag, c), 64'(b_odat), 64'(2 * exp_a + 1));
                exp_a++;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        force_b  = 1'b0;
        chk({tag, " wren"},     h_wren, v.wren);
        chk({tag, " rden"},     h_rden, v.rden);
        chk({tag, " mac_en"},   h_mac,  v.mac);
        chk({tag, " done"},     h_done, v.done);
        chk({tag, " busy"},     h_busy, v.busy);
        chk({tag, " mac_clr"},  h_clr,  v.clr);
        chk({tag, " in_ready"}, h_rdy,  v.rdy);
        chk({tag, " a_full"},   h_full, v.full);
        chk({tag, " err"},      h_err,  v.err);
        chk({tag, " lockstep"}, 64'(lockstep_bad), 64'd0);
    endtask

    function automatic logic [9:0] outs();
        return {in_ready, a_wren, b_wren, a_rden, b_rden, mac_clr, mac_en, busy, done, err};
    endfunction

    vec_t post_rst;
    int   rd_seen;

    initial begin
        //            len    stall  forceb wren   rden     mac      done     busy     clr  rdy    full   err
        tbl[0] = '{4'd4,  64'h0,  64'h0,  64'h1E, 64'h1E0, 64'h3C0, 64'h400, 64'h3FE, 64'h2, 64'h1E, 64'h0, 64'h0};
        tbl[1] = '{4'd3,  64'h1C, 64'h0,  64'h62, 64'h380, 64'h700, 64'h800, 64'h7FE, 64'h2, 64'h7E, 64'h0, 64'h0};
        tbl[2] = '{4'd8,  64'h0,  64'h0,  64'h1FE, 64'h1FE00, 64'h3FC00, 64'h40000, 64'h3FFFE, 64'h2, 64'h1FE, 64'h200, 64'h0};
        tbl[3] = '{4'd12, 64'h0,  64'h0,  64'h1FE, 64'h1FE00, 64'h3FC00, 64'h40000, 64'h3FFFE, 64'h2, 64'h1FE, 64'h200, 64'h0};
        tbl[4] = '{4'd0,  64'h0,  64'h0,  64'h0,  64'h0,   64'h0,   64'h2,   64'h0,   64'h2, 64'h0,  64'h0, 64'h0};
        tbl[5] = '{4'd2,  64'h0,  64'h38, 64'h6,  64'hC0,  64'h180, 64'h200, 64'h1FE, 64'h2, 64'h6,  64'h0, 64'hFFFFF0};
        tbl[6] = '{4'd1,  64'h0,  64'h0,  64'h2,  64'h4,   64'h8,   64'h10,  64'hE,   64'h2, 64'h2,  64'h0, 64'h1};
        post_rst = '{4'd2, 64'h0, 64'h0,  64'h6,  64'h18,  64'h30,  64'h40,  64'h3E,  64'h2, 64'h6,  64'h0, 64'h0};

        rst_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        force_b  = 1'b0;
        #3;
        chk("reset outputs", 64'(outs()), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle outputs", 64'(outs()), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_job($sformatf("row%0d", i), tbl[i]);
        end

        // Reset in the middle of DRAIN: after two of four reads, cycle 7
        rd_seen = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            start    = (c == 0);
            len      = 4'd4;
            in_valid = 1'b1;
            @(negedge clk);
            if (a_rden) rd_seen++;
        end
        start = 1'b0;
        chk("rst reads before", 64'(rd_seen), 64'd2);
        @(posedge clk);
        #1;
        chk("rst pre outputs", 64'(outs()), 64'(10'b0001101100));
        rst_n = 1'b0;
        #1;
        chk("rst async outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        chk("rst held outputs", 64'(outs()), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        run_job("post_rst", post_rst);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
